apb3_master: RTL and testbench
==============================

# apb3_master

Single-outstanding APB3 initiator converting a valid/ready command/response interface into APB3 SETUP/ACCESS transfers. Lets fabric-side logic (test sequencers, DMA helpers, board-management FSMs) drive APB3 peripherals, including the APB3 slave responder hung off the SoC's `io_apbSlave_0` port, without the RISC-V core. Adds a wait-state timeout so a hung slave cannot stall the requester.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: PADDR / cmd_addr width.
- `DATA_WIDTH`, 32: PWDATA / PRDATA / data width.
- `TIMEOUT_CYCLES`, 256: max ACCESS cycles with PREADY low before abort. 0 = timeout disabled. Counter width `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.

Ports:
- `clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when valid & ready.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: target address.
- `cmd_wdata` in DATA_WIDTH: write data, ignored for reads.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when valid & ready.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes and for timeouts.
- `rsp_error` out 1: PSLVERROR seen or timeout.
- `rsp_timeout` out 1: transfer aborted by timeout.
- `PADDR` out ADDR_WIDTH, `PSEL` out 1, `PENABLE` out 1, `PWRITE` out 1, `PWDATA` out DATA_WIDTH: APB3 request.
- `PREADY` in 1, `PRDATA` in DATA_WIDTH, `PSLVERROR` in 1: APB3 completion.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs registered except `cmd_ready`, which is `state==IDLE`.
- IDLE: on cmd_valid, latch write/addr/wdata into PWRITE/PADDR/PWDATA; go to SETUP.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle; go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. The wait counter clears on entry and increments each cycle PREADY=0.
  - PREADY=1: capture PRDATA into rsp_rdata for reads, 0 for writes. rsp_error=PSLVERROR, rsp_timeout=0. Drop PSEL/PENABLE. Go to RESP.
  - PREADY=0 and counter==TIMEOUT_CYCLES-1 (timeout enabled): abort. Drop PSEL/PENABLE, rsp_rdata=0, rsp_error=1, rsp_timeout=1. Go to RESP.
  - If PREADY=1 on the same cycle the timeout would fire, the completion wins: normal response.
- RESP: rsp_valid=1, with rsp_* held stable until rsp_ready. On rsp_ready go to IDLE with rsp_valid=0.
- PADDR/PWRITE/PWDATA are constant from SETUP through the last ACCESS cycle. They hold their last values while idle.
- PSLVERROR and PRDATA are sampled only in ACCESS with PREADY=1. They are ignored otherwise.
- Reset (any state, including mid-ACCESS): next edge gives state=IDLE and all outputs 0. The in-flight transfer is dropped with no response.

## Timing
- Reset values: PADDR=0, PWDATA=0, PWRITE=0, PSEL=0, PENABLE=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0. cmd_ready=1 once reset deasserts.
- Command accepted at edge k: SETUP in cycle k+1, ACCESS from k+2. A zero-wait slave gives rsp_valid in cycle k+3.
- Each PREADY wait state adds 1 cycle. Timeout gives rsp_valid TIMEOUT_CYCLES+2 cycles after acceptance.
- Back-to-back with rsp_ready tied high: 4 cycles per transfer. cmd_ready is low in SETUP/ACCESS/RESP.
- PSEL never asserts while PENABLE=0 except the single SETUP cycle. PENABLE never asserts without PSEL.

## Test plan
- Write 0x1234 <- 0xDEADBEEF, PREADY tied high: SETUP 1 cycle, ACCESS 1 cycle with PWRITE=1; rsp_valid 3 cycles after accept with rdata=0, error=0, timeout=0.
- Read 0x0010, slave holds PREADY low 2 cycles then returns 0xA5A5_0001: ACCESS lasts 3 cycles with PADDR stable; rsp_rdata=0xA5A50001, error=0.
- Read with PSLVERROR=1 on the completing cycle: rsp_error=1, rsp_timeout=0, rsp_rdata=PRDATA.
- TIMEOUT_CYCLES=4 with PREADY stuck low: exactly 4 ACCESS cycles, then PSEL=0, rsp_error=1, rsp_timeout=1, rdata=0. Repeat with PREADY=1 on the 4th cycle: normal response.
- Hold rsp_ready low 5 cycles: rsp_* stable, cmd_ready=0, no PSEL. Release: IDLE next cycle and the pending cmd_valid is accepted.
- Assert reset during ACCESS with wait states: next edge PSEL=PENABLE=0, rsp_valid=0, cmd_ready=1; no response is ever issued for the dropped transfer.

Source files
------------

// File: rtl/apb3_master.sv
// apb3_master: single-outstanding APB3 initiator.
// Converts a valid/ready command/response handshake into APB3 SETUP/ACCESS transfers.
// A wait-state timeout stops a slave that never asserts PREADY from hanging the requester.
//
// Ports:
//   clk, reset                        - clock and synchronous active-high reset
//   cmd_valid/cmd_ready               - command handshake (cmd_ready is high only when idle)
//   cmd_write, cmd_addr, cmd_wdata    - command payload
//   rsp_valid/rsp_ready               - response handshake
//   rsp_rdata, rsp_error, rsp_timeout - response payload (rdata is 0 for writes and timeouts)
//   PADDR, PSEL, PENABLE, PWRITE, PWDATA - APB3 request, all registered
//   PREADY, PRDATA, PSLVERROR         - APB3 completion, sampled only in ACCESS with PREADY high
module apb3_master #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERROR
);

  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CntW      = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned CntLastI  = TimeoutEn ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CntW-1:0] CntLast = CntW'(CntLastI);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  timeout_hit;

  // Fires on the last tolerated wait cycle; a simultaneous PREADY takes priority downstream.
  assign timeout_hit = TimeoutEn && !PREADY && (cnt_q == CntLast);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cmd_valid) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (PREADY || timeout_hit) state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and the wait counter
  always_comb begin
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          psel_d   = 1'b1;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      StAccess: begin
        if (PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_error_d   = PSLVERROR;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_master.sv
module tb_apb3_master;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [15:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERROR;

  apb3_master #(
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERROR  (PSLVERROR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit checking = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transfer is either in its setup beat, in its access beats,
  // or finished and waiting to be consumed as a response.
  bit        m_busy, m_setup, m_pend;
  int        m_acc;
  bit        m_write;
  bit [15:0] m_addr;
  bit [31:0] m_wdata;
  bit [31:0] m_rdata;
  bit        m_err, m_to;

  initial begin
    m_busy = 0; m_setup = 0; m_pend = 0; m_acc = 0;
    m_write = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_err = 0; m_to = 0;
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("cmd_ready", cmd_ready, !m_busy && !m_pend);
        chk("psel", PSEL, m_busy);
        chk("penable", PENABLE, m_busy && !m_setup);
        chk("paddr", PADDR, m_addr);
        chk("pwrite", PWRITE, m_write);
        chk("pwdata", PWDATA, m_wdata);
        chk("rsp_valid", rsp_valid, m_pend);
        if (m_pend) begin
          chk("rsp_rdata", rsp_rdata, m_rdata);
          chk("rsp_error", rsp_error, m_err);
          chk("rsp_timeout", rsp_timeout, m_to);
        end
      end
      // Inputs only change just after a rising edge, so these are what the next edge sees.
      if (reset) begin
        m_busy = 0; m_setup = 0; m_pend = 0;
        m_addr = 0; m_wdata = 0; m_write = 0;
      end else if (m_pend) begin
        if (rsp_ready) m_pend = 0;
      end else if (m_busy) begin
        if (m_setup) begin
          m_setup = 0;
          m_acc   = 0;
        end else begin
          m_acc++;
          if (PREADY) begin
            m_busy = 0; m_pend = 1;
            m_rdata = m_write ? 32'h0 : PRDATA;
            m_err = PSLVERROR; m_to = 0;
          end else if (m_acc == TO) begin
            m_busy = 0; m_pend = 1;
            m_rdata = 0; m_err = 1; m_to = 1;
          end
        end
      end else if (cmd_valid) begin
        m_busy = 1; m_setup = 1;
        m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                       output int acc_cyc);
    int  n;
    bit  took;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0; took = 0; acc_cyc = -1;
    while (!took && n < 50) begin
      took = cmd_ready;
      if (took) acc_cyc = cyc;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    if (!took) chk("accept_bound", 64'd0, 64'd1);
  endtask

  initial begin
    int a0, a1, n, acc;
    reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 1'b1; PREADY = 1'b1; PRDATA = 0; PSLVERROR = 0;
    tick(); tick(); tick();
    checking = 1'b1;
    // Reset values
    chk("rst_psel", PSEL, 0);          chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);        chk("rst_pwdata", PWDATA, 0);
    chk("rst_pwrite", PWRITE, 0);      chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);    chk("rst_error", rsp_error, 0);
    chk("rst_timeout", rsp_timeout, 0);
    reset = 1'b0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);

    // Zero-wait write; PRDATA junk must not leak into a write response
    PRDATA = 32'h9999_9999;
    issue(1'b1, 16'h1234, 32'hDEAD_BEEF, a0);
    chk("wr_setup_psel", PSEL, 1);     chk("wr_setup_penable", PENABLE, 0);
    tick();
    chk("wr_acc_penable", PENABLE, 1); chk("wr_acc_pwrite", PWRITE, 1);
    chk("wr_acc_paddr", PADDR, 16'h1234); chk("wr_acc_pwdata", PWDATA, 32'hDEAD_BEEF);
    tick();
    chk("wr_rsp_valid", rsp_valid, 1); chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_rsp_error", rsp_error, 0); chk("wr_rsp_to", rsp_timeout, 0);
    chk("wr_rsp_psel", PSEL, 0);
    tick();

    // Read with two wait states
    PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
    issue(1'b0, 16'h0010, 32'h0, a0);
    tick(); chk("rd_w1_penable", PENABLE, 1); chk("rd_w1_paddr", PADDR, 16'h0010);
    tick(); chk("rd_w2_penable", PENABLE, 1); chk("rd_w2_paddr", PADDR, 16'h0010);
    tick();
    PREADY = 1'b1; PRDATA = 32'hA5A5_0001;
    chk("rd_w3_penable", PENABLE, 1);
    tick();
    chk("rd_rsp_valid", rsp_valid, 1); chk("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
    chk("rd_rsp_error", rsp_error, 0);
    tick();

    // Read completing with PSLVERROR
    PSLVERROR = 1'b1; PRDATA = 32'h1357_9BDF;
    issue(1'b0, 16'h0020, 32'h0, a0);
    tick(); tick();
    chk("err_rsp_valid", rsp_valid, 1); chk("err_rsp_error", rsp_error, 1);
    chk("err_rsp_to", rsp_timeout, 0);  chk("err_rsp_rdata", rsp_rdata, 32'h1357_9BDF);
    PSLVERROR = 1'b0;
    tick();

    // Timeout with PREADY stuck low
    PREADY = 1'b0; PRDATA = 32'h7777_7777;
    issue(1'b0, 16'h0030, 32'h0, a0);
    n = 1; acc = 0;
    while (!rsp_valid && n < 20) begin
      tick(); n++;
      if (PENABLE) acc++;
    end
    chk("to_latency", n, TO + 2);      chk("to_access_cycles", acc, TO);
    chk("to_psel", PSEL, 0);           chk("to_error", rsp_error, 1);
    chk("to_flag", rsp_timeout, 1);    chk("to_rdata", rsp_rdata, 0);
    tick();

    // PREADY rises on the last tolerated cycle: completion wins
    issue(1'b0, 16'h0040, 32'h0, a0);
    for (int i = 0; i < 4; i++) tick();
    PREADY = 1'b1; PRDATA = 32'h0BAD_F00D;
    tick();
    chk("race_valid", rsp_valid, 1);   chk("race_error", rsp_error, 0);
    chk("race_to", rsp_timeout, 0);    chk("race_rdata", rsp_rdata, 32'h0BAD_F00D);
    tick();

    // Response back-pressure with a command already waiting
    rsp_ready = 1'b0;
    issue(1'b1, 16'h0050, 32'h1122_3344, a0);
    tick(); tick();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0060; cmd_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1); chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_psel", PSEL, 0);
      if (i == 4) rsp_ready = 1'b1;
      tick();
    end
    chk("bp_idle_cmd_ready", cmd_ready, 1); chk("bp_idle_rsp_valid", rsp_valid, 0);
    tick();
    chk("bp_next_psel", PSEL, 1); chk("bp_next_paddr", PADDR, 16'h0060);
    cmd_valid = 1'b0;
    PRDATA = 32'h0000_0060;
    for (int i = 0; i < 4; i++) tick();

    // Back-to-back: one transfer every 4 cycles with rsp_ready high
    issue(1'b1, 16'h0100, 32'h0000_0001, a0);
    issue(1'b1, 16'h0104, 32'h0000_0002, a1);
    chk("b2b_spacing", a1 - a0, 4);
    for (int i = 0; i < 4; i++) tick();

    // Reset in the middle of a waited ACCESS drops the transfer
    PREADY = 1'b0;
    issue(1'b1, 16'h0070, 32'hCAFE_F00D, a0);
    tick(); tick();
    chk("mid_penable", PENABLE, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_psel", PSEL, 0);      chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_valid", rsp_valid, 0); chk("mid_rst_cmd_ready", cmd_ready, 1);
    reset = 1'b0; PREADY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_no_rsp", rsp_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

endmodule
